alu_stage: RTL and testbench

Parametrised execute stage: a registered ALU with a ready/valid handshake on both sides and a two-entry skid buffer. It sits between the decode/register-read pipeline register and the memory stage. Operand width is a parameter, the op set is a superset of the existing 3-bit ALU encoding, and the stage supports back-pressure and flush.

---
 rtl/alu_stage.sv | 102 ++++++++++
 tb/tb_alu_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_stage.sv
// alu_stage: registered execute-stage ALU with ready/valid on both sides.
// A second (skid) register absorbs one result so in_ready never depends on out_ready.
module alu_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_op,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic                  out_zero,
    output logic [TAG_WIDTH-1:0]  out_tag
);
    localparam int SW = $clog2(DATA_WIDTH);

    logic [SW-1:0]         shamt;
    logic [DATA_WIDTH-1:0] res;
    logic                  accept, drain;
    logic                  o_valid_q, o_valid_d, s_valid_q, s_valid_d;
    logic [DATA_WIDTH-1:0] o_data_q, o_data_d, s_data_q, s_data_d;
    logic [TAG_WIDTH-1:0]  o_tag_q, o_tag_d, s_tag_q, s_tag_d;

    assign shamt = in_b[SW-1:0];

    always_comb begin
        res = '0;
        case (in_op)
            4'b0000: res = in_a & in_b;
            4'b0001: res = in_a | in_b;
            4'b0010: res = in_a + in_b;
            4'b0110: res = in_a - in_b;
            4'b0011: res = in_a ^ in_b;
            4'b0111: res = {{(DATA_WIDTH-1){1'b0}}, $signed(in_a) < $signed(in_b)};
            4'b0101: res = {{(DATA_WIDTH-1){1'b0}}, in_a < in_b};
            4'b0100: res = in_a << shamt;
            4'b1000: res = in_a >> shamt;
            4'b1001: res = $unsigned($signed(in_a) >>> shamt);
            default: res = '0;
        endcase
    end

    assign in_ready   = !s_valid_q;
    assign accept     = in_valid && in_ready;
    assign drain      = o_valid_q && out_ready;
    assign out_valid  = o_valid_q;
    assign out_result = o_data_q;
    assign out_zero   = (o_data_q == '0);
    assign out_tag    = o_tag_q;

    always_comb begin
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        o_tag_d   = o_tag_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        s_tag_d   = s_tag_q;
        if (flush) begin
            o_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (s_valid_q && drain) begin
            o_data_d  = s_data_q;
            o_tag_d   = s_tag_q;
            s_valid_d = 1'b0;
        end else if (accept && (!o_valid_q || drain)) begin
            o_valid_d = 1'b1;
            o_data_d  = res;
            o_tag_d   = in_tag;
        end else if (accept) begin
            s_valid_d = 1'b1;
            s_data_d  = res;
            s_tag_d   = in_tag;
        end else if (drain) begin
            o_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_tag_q   <= '0;
            s_valid_q <= 1'b0;
            s_data_q  <= '0;
            s_tag_q   <= '0;
        end else begin
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_tag_q   <= o_tag_d;
            s_valid_q <= s_valid_d;
            s_data_q  <= s_data_d;
            s_tag_q   <= s_tag_d;
        end
    end
endmodule

// File: tb/tb_alu_stage.sv
// tb_alu_stage: directed vectors at 32 bits plus random handshake streams at 16 and 64 bits.
module tb_alu_stage;
    logic        clk = 1'b0, reset_n = 1'b0, flush = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, out_zero;
    logic [3:0]  in_op = 4'b0;
    logic [31:0] in_a = '0, in_b = '0, out_result;
    logic [4:0]  in_tag = '0, out_tag;

    logic        v16 = 1'b0, r16 = 1'b0, ir16, ov16, oz16;
    logic [3:0]  op16 = 4'b0010;
    logic [15:0] a16 = '0, b16 = '0, res16;
    logic [4:0]  t16 = '0, ot16;
    logic        v64 = 1'b0, r64 = 1'b0, ir64, ov64, oz64;
    logic [3:0]  op64 = 4'b0010;
    logic [63:0] a64 = '0, b64 = '0, res64;
    logic [4:0]  t64 = '0, ot64;

    int n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    alu_stage dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero), .out_tag(out_tag)
    );
    alu_stage #(.DATA_WIDTH(16)) dut16 (
        .clk(clk), .reset_n(reset_n), .flush(1'b0), .in_valid(v16), .in_ready(ir16),
        .in_op(op16), .in_a(a16), .in_b(b16), .in_tag(t16), .out_valid(ov16),
        .out_ready(r16), .out_result(res16), .out_zero(oz16), .out_tag(ot16)
    );
    alu_stage #(.DATA_WIDTH(64)) dut64 (
        .clk(clk), .reset_n(reset_n), .flush(1'b0), .in_valid(v64), .in_ready(ir64),
        .in_op(op64), .in_a(a64), .in_b(b64), .in_tag(t64), .out_valid(ov64),
        .out_ready(r64), .out_result(res64), .out_zero(oz64), .out_tag(ot64)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
        in_valid = v;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = t;
    endtask

    task automatic op_chk(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        drive(1'b1, op, a, b, 5'd9);
        step();
        in_valid = 1'b0;
        check(name, out_result, exp);
        check({name, "_v"}, out_valid, 1'b1);
        check({name, "_z"}, out_zero, exp == 32'h0);
    endtask

    logic [15:0] q16[$];
    logic [4:0]  qt16[$];
    logic [63:0] q64[$];
    logic [4:0]  qt64[$];

    initial begin
        #3;
        check("rst_valid", out_valid, 1'b0);
        check("rst_ready", in_ready, 1'b1);
        check("rst_result", out_result, 32'h0);
        check("rst_zero", out_zero, 1'b1);
        check("rst_tag", out_tag, 5'd0);
        #4 reset_n = 1'b1;
        step();

        out_ready = 1'b1;
        op_chk("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h1, 32'h0);
        op_chk("sub", 4'b0110, 32'd5, 32'd7, 32'hFFFF_FFFE);
        op_chk("slt", 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1);
        op_chk("sltu", 4'b0101, 32'hFFFF_FFFF, 32'd1, 32'd0);
        op_chk("sra", 4'b1001, 32'h8000_0000, 32'd4, 32'hF800_0000);
        op_chk("srl", 4'b1000, 32'h8000_0000, 32'd4, 32'h0800_0000);
        op_chk("sll_mask", 4'b0100, 32'd1, 32'd33, 32'd2);
        op_chk("and", 4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234);
        op_chk("or", 4'b0001, 32'hF000_0001, 32'h0000_0F10, 32'hF000_0F11);
        op_chk("xor", 4'b0011, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);
        op_chk("bad_op", 4'b1111, 32'h1234_5678, 32'h1, 32'h0);
        step();
        check("idle", out_valid, 1'b0);

        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 4'b0010, i, 32'd100, 5'(i));
            check("b2b_rdy", in_ready, 1'b1);
            step();
            check("b2b_tag", out_tag, i);
            check("b2b_res", out_result, i + 100);
            check("b2b_v", out_valid, 1'b1);
        end
        in_valid = 1'b0;
        step();
        check("b2b_end", out_valid, 1'b0);

        out_ready = 1'b0;
        drive(1'b1, 4'b0010, 32'd1, 32'd1, 5'd1);
        step();
        check("stl_a_v", out_valid, 1'b1);
        check("stl_rdy1", in_ready, 1'b1);
        drive(1'b1, 4'b0010, 32'd2, 32'd2, 5'd2);
        step();
        check("stl_rdy0", in_ready, 1'b0);
        check("stl_tag_a", out_tag, 5'd1);
        drive(1'b1, 4'b0010, 32'd7, 32'd7, 5'd7);
        step();
        in_valid = 1'b0;
        check("stl_hold_t", out_tag, 5'd1);
        check("stl_hold_r", out_result, 32'd2);
        check("stl_rdy0b", in_ready, 1'b0);
        out_ready = 1'b1;
        step();
        check("rel_tag_b", out_tag, 5'd2);
        check("rel_res_b", out_result, 32'd4);
        check("rel_v", out_valid, 1'b1);
        check("rel_rdy", in_ready, 1'b1);
        step();
        check("rel_empty", out_valid, 1'b0);

        out_ready = 1'b0;
        drive(1'b1, 4'b0010, 32'd3, 32'd0, 5'd3);
        step();
        drive(1'b1, 4'b0010, 32'd4, 32'd0, 5'd4);
        step();
        check("fl_full", in_ready, 1'b0);
        drive(1'b1, 4'b0010, 32'd5, 32'd0, 5'd5);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_v", out_valid, 1'b0);
        check("fl_rdy", in_ready, 1'b1);
        out_ready = 1'b1;
        step();
        check("fl_gone", out_valid, 1'b0);

        out_ready = 1'b0;
        drive(1'b1, 4'b0010, 32'd6, 32'd0, 5'd6);
        step();
        drive(1'b1, 4'b0010, 32'd8, 32'd0, 5'd8);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl1_v", out_valid, 1'b0);
        check("fl1_rdy", in_ready, 1'b1);

        drive(1'b1, 4'b0010, 32'd10, 32'd0, 5'd10);
        step();
        drive(1'b1, 4'b0010, 32'd11, 32'd0, 5'd11);
        step();
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("ar_v", out_valid, 1'b0);
        check("ar_rdy", in_ready, 1'b1);
        check("ar_tag", out_tag, 5'd0);
        check("ar_zero", out_zero, 1'b1);
        #1 reset_n = 1'b1;
        out_ready = 1'b1;
        step();
        check("ar_idle", out_valid, 1'b0);
        drive(1'b1, 4'b0110, 32'd20, 32'd8, 5'd12);
        step();
        in_valid = 1'b0;
        check("ar_new_r", out_result, 32'd12);
        check("ar_new_t", out_tag, 5'd12);
        step();

        for (int c = 0; c < 10000; c++) begin
            v16 = 1'($urandom_range(0, 1));
            r16 = 1'($urandom_range(0, 1));
            op16 = $urandom_range(0, 1) ? 4'b0011 : 4'b0010;
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            t16 = 5'(c);
            v64 = 1'($urandom_range(0, 1));
            r64 = 1'($urandom_range(0, 1));
            op64 = $urandom_range(0, 1) ? 4'b0011 : 4'b0010;
            a64 = {$urandom, $urandom};
            b64 = {$urandom, $urandom};
            t64 = 5'(c + 3);
            if (ov16 && r16) begin
                if (q16.size() == 0) check("dup16", 1'b0, 1'b1);
                else begin
                    check("rnd16_r", res16, q16.pop_front());
                    check("rnd16_t", ot16, qt16.pop_front());
                end
            end
            if (ov64 && r64) begin
                if (q64.size() == 0) check("dup64", 1'b0, 1'b1);
                else begin
                    check("rnd64_r", res64, q64.pop_front());
                    check("rnd64_t", ot64, qt64.pop_front());
                end
            end
            if (v16 && ir16) begin
                q16.push_back(op16 == 4'b0011 ? a16 ^ b16 : a16 + b16);
                qt16.push_back(t16);
            end
            if (v64 && ir64) begin
                q64.push_back(op64 == 4'b0011 ? a64 ^ b64 : a64 + b64);
                qt64.push_back(t64);
            end
            step();
        end
        v16 = 1'b0;
        v64 = 1'b0;
        r16 = 1'b1;
        r64 = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (ov16) begin
                if (q16.size() == 0) check("dup16", 1'b0, 1'b1);
                else check("rnd16_r", res16, q16.pop_front());
            end
            if (ov64) begin
                if (q64.size() == 0) check("dup64", 1'b0, 1'b1);
                else check("rnd64_r", res64, q64.pop_front());
            end
            step();
        end
        check("loss16", q16.size(), 0);
        check("loss64", q64.size(), 0);
        check("end16_v", ov16, 1'b0);
        check("end64_v", ov64, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
